// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid_if
// Description : Valid/ready/payload handshake bundle between pipeline stages.
//               The master drives valid and data; the slave drives ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_skid_if #(
    parameter int PAYLOAD_W = 80
) ();
    logic                 valid;
    logic                 ready;
    logic [PAYLOAD_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Inter-stage pipeline register with valid/ready handshake,
//               2-entry skid buffer, synchronous flush of control bits and a
//               saturating backpressure (stall) counter. Payload is
//               {CTRL, DATA} with CTRL in the upper CTRL_W bits. in_ready
//               depends on registered state only, so no combinational ready
//               path crosses the stage.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int PAYLOAD_W = 80,
    parameter int CTRL_W    = 8,
    parameter int CNT_W     = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,      // active-high synchronous reset
    pipe_stage_skid_if.slave      up,         // in_valid / in_ready / in_data
    pipe_stage_skid_if.master     dn,         // out_valid / out_ready / out_data
    input  wire logic             flush,
    input  wire logic             stat_clr,
    output logic [1:0]            occupancy,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int              c_DATA_W    = PAYLOAD_W - CTRL_W;
    localparam logic [1:0]      c_ST_EMPTY  = 2'd0;
    localparam logic [1:0]      c_ST_ONE    = 2'd1;
    localparam logic [1:0]      c_ST_FULL   = 2'd2;
    localparam logic [CNT_W-1:0] c_STALL_MAX = {CNT_W{1'b1}};

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [PAYLOAD_W-1:0] r_main;
    logic [PAYLOAD_W-1:0] r_skid;
    logic [CNT_W-1:0]     r_stall_cnt;

    logic w_in_valid;
    logic w_out_ready;
    logic w_in_ready;
    logic w_out_valid;
    logic w_in_fire;
    logic w_out_fire;
    logic w_main_load_in;
    logic w_main_load_skid;
    logic w_skid_load_in;

    assign w_in_valid  = up.valid;
    assign w_out_ready = dn.ready;

    // Handshake qualifiers come straight from the state register
    assign w_out_valid = (r_state != c_ST_EMPTY);
    assign w_in_ready  = (r_state != c_ST_FULL);
    assign w_in_fire   = w_in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & w_out_ready;

    assign up.ready  = w_in_ready;
    assign dn.valid  = w_out_valid;
    assign dn.data   = r_main;
    assign occupancy = r_state;
    assign stall_cnt = r_stall_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and entry-load decode; flush empties the stage and drops any incoming payload
    always_comb begin
        w_state_nxt      = r_state;
        w_main_load_in   = 1'b0;
        w_main_load_skid = 1'b0;
        w_skid_load_in   = 1'b0;
        case (r_state)
            c_ST_EMPTY: begin
                if (w_in_fire) begin
                    w_main_load_in = 1'b1;
                    w_state_nxt    = c_ST_ONE;
                end
            end
            c_ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_load_in = 1'b1;
                end else if (w_in_fire) begin
                    w_skid_load_in = 1'b1;
                    w_state_nxt    = c_ST_FULL;
                end else if (w_out_fire) begin
                    // main keeps its stale value; out_valid=0 qualifies it away
                    w_state_nxt = c_ST_EMPTY;
                end
            end
            c_ST_FULL: begin
                if (w_out_fire) begin
                    w_main_load_skid = 1'b1;
                    w_state_nxt      = c_ST_ONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_EMPTY;
            end
        endcase
        if (flush) begin
            w_state_nxt      = c_ST_EMPTY;
            w_main_load_in   = 1'b0;
            w_main_load_skid = 1'b0;
            w_skid_load_in   = 1'b0;
        end
    end

    // Payload entries; flush clears only the control field so the data bits stay untouched
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (flush) begin
            r_main <= {{CTRL_W{1'b0}}, r_main[c_DATA_W-1:0]};
            r_skid <= {{CTRL_W{1'b0}}, r_skid[c_DATA_W-1:0]};
        end else begin
            if (w_main_load_in) begin
                r_main <= up.data;
            end else if (w_main_load_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_load_in) begin
                r_skid <= up.data;
            end
        end
    end

    // Saturating count of cycles where downstream stalls a valid payload; clear wins
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_stall_cnt <= '0;
        end else if (stat_clr) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !w_out_ready && (r_stall_cnt != c_STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Directed and randomised self-checking bench for
//               pipe_stage_skid (default widths plus a CNT_W=4 instance for
//               stall counter saturation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int c_PW = 80;

    logic clk;
    logic rst_n;
    logic flush;
    logic stat_clr;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        s_flush;
    logic        s_stat_clr;
    logic [1:0]  s_occupancy;
    logic [3:0]  s_stall_cnt;

    int checks;
    int failures;

    pipe_stage_skid_if #(.PAYLOAD_W(c_PW)) u_if ();
    pipe_stage_skid_if #(.PAYLOAD_W(c_PW)) d_if ();
    pipe_stage_skid_if #(.PAYLOAD_W(c_PW)) su_if ();
    pipe_stage_skid_if #(.PAYLOAD_W(c_PW)) sd_if ();

    pipe_stage_skid #(.PAYLOAD_W(c_PW), .CTRL_W(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .up        (u_if.slave),
        .dn        (d_if.master),
        .flush     (flush),
        .stat_clr  (stat_clr),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_skid #(.PAYLOAD_W(c_PW), .CTRL_W(8), .CNT_W(4)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .up        (su_if.slave),
        .dn        (sd_if.master),
        .flush     (s_flush),
        .stat_clr  (s_stat_clr),
        .occupancy (s_occupancy),
        .stall_cnt (s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [79:0] mk(input logic [7:0] i);
        return {i ^ 8'hA5, 64'h0, i};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [79:0] q[$];
    logic [79:0] exp_v;
    logic [79:0] a_v, b_v, c_v, e_v, f_v, g_v, d_v;
    logic [31:0] seq;
    bit          in_fire, out_fire;
    int          guard;

    initial begin
        checks   = 0;
        failures = 0;
        seq      = 0;
        rst_n    = 1'b1;
        flush    = 1'b0;
        stat_clr = 1'b0;
        u_if.valid = 1'b1;
        u_if.data  = mk(8'h99);
        d_if.ready = 1'b0;
        s_flush    = 1'b0;
        s_stat_clr = 1'b0;
        su_if.valid = 1'b0;
        su_if.data  = '0;
        sd_if.ready = 1'b0;

        // ---- 1: reset with in_valid held high
        step();
        step();
        chk("rst_out_valid", 128'(d_if.valid), 128'd0);
        chk("rst_in_ready",  128'(u_if.ready), 128'd1);
        chk("rst_occupancy", 128'(occupancy),  128'd0);
        chk("rst_stall_cnt", 128'(stall_cnt),  128'd0);
        chk("rst_out_data",  128'(d_if.data),  128'd0);
        rst_n      = 1'b0;
        u_if.valid = 1'b0;

        // ---- 2: streaming with out_ready=1
        d_if.ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            u_if.valid = 1'b1;
            u_if.data  = mk(8'(i));
            step();
            chk("stream_data",     128'(d_if.data),  128'(mk(8'(i))));
            chk("stream_valid",    128'(d_if.valid), 128'd1);
            chk("stream_in_ready", 128'(u_if.ready), 128'd1);
        end
        u_if.valid = 1'b0;
        step();
        chk("stream_drain_occ",   128'(occupancy), 128'd0);
        chk("stream_drain_valid", 128'(d_if.valid), 128'd0);
        chk("stream_stall",       128'(stall_cnt), 128'd0);

        // ---- 3: backpressure fills skid, C held upstream
        a_v = mk(8'h11); b_v = mk(8'h12); c_v = mk(8'h13);
        d_if.ready = 1'b0;
        u_if.valid = 1'b1;
        u_if.data  = a_v;
        step();
        chk("bp_occ_a",  128'(occupancy), 128'd1);
        chk("bp_data_a", 128'(d_if.data), 128'(a_v));
        u_if.data = b_v;
        step();
        chk("bp_occ_full",  128'(occupancy),  128'd2);
        chk("bp_in_ready0", 128'(u_if.ready), 128'd0);
        chk("bp_skid_b",    128'(dut.r_skid), 128'(b_v));
        u_if.data = c_v;
        step();
        chk("bp_hold_data",  128'(d_if.data), 128'(a_v));
        chk("bp_hold_occ",   128'(occupancy), 128'd2);
        chk("bp_stall_2",    128'(stall_cnt), 128'd2);
        d_if.ready = 1'b1;
        step();
        chk("bp_deliver_b", 128'(d_if.data), 128'(b_v));
        chk("bp_occ_one",   128'(occupancy), 128'd1);
        step();
        chk("bp_deliver_c", 128'(d_if.data), 128'(c_v));
        u_if.valid = 1'b0;
        step();
        chk("bp_empty",       128'(occupancy), 128'd0);
        chk("bp_stall_final", 128'(stall_cnt), 128'd2);

        // ---- 4: flush while FULL with in_valid high
        e_v = mk(8'h21); f_v = mk(8'h22); g_v = mk(8'h23); d_v = mk(8'h24);
        d_if.ready = 1'b0;
        u_if.valid = 1'b1;
        u_if.data  = e_v;
        step();
        u_if.data = f_v;
        step();
        chk("fl_pre_occ", 128'(occupancy), 128'd2);
        u_if.data = g_v;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_occ",       128'(occupancy),  128'd0);
        chk("fl_out_valid", 128'(d_if.valid), 128'd0);
        chk("fl_in_ready",  128'(u_if.ready), 128'd1);
        chk("fl_main_ctrl", 128'(d_if.data),  128'({8'h00, e_v[71:0]}));
        chk("fl_skid_ctrl", 128'(dut.r_skid), 128'({8'h00, f_v[71:0]}));
        chk("fl_stall",     128'(stall_cnt),  128'd4);
        u_if.data  = d_v;
        d_if.ready = 1'b1;
        step();
        chk("fl_d_data", 128'(d_if.data), 128'(d_v));
        chk("fl_d_occ",  128'(occupancy), 128'd1);
        u_if.valid = 1'b0;
        step();
        chk("fl_after_occ", 128'(occupancy), 128'd0);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("statclr_main", 128'(stall_cnt), 128'd0);

        // ---- 5: stall counter saturation on the CNT_W=4 instance
        su_if.valid = 1'b1;
        su_if.data  = mk(8'h31);
        step();
        su_if.valid = 1'b0;
        chk("sat_occ", 128'(s_occupancy), 128'd1);
        chk("sat_start", 128'(s_stall_cnt), 128'd0);
        for (int i = 0; i < 10; i++) step();
        chk("sat_mid", 128'(s_stall_cnt), 128'd10);
        for (int i = 0; i < 10; i++) step();
        chk("sat_hold", 128'(s_stall_cnt), 128'd15);
        s_stat_clr = 1'b1;
        step();
        s_stat_clr = 1'b0;
        chk("sat_clr", 128'(s_stall_cnt), 128'd0);
        step();
        chk("sat_restart", 128'(s_stall_cnt), 128'd1);

        // ---- 6: random valid/ready with scoreboard
        for (int cyc = 0; cyc < 10000; cyc++) begin
            u_if.valid = ($urandom_range(0, 3) != 0);
            u_if.data  = {8'hC3, 40'h0, seq};
            d_if.ready = ($urandom_range(0, 2) != 0);
            #1;
            in_fire  = u_if.valid & u_if.ready;
            out_fire = d_if.valid & d_if.ready;
            if (out_fire) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected", 128'(d_if.data), 128'd0);
                end else begin
                    exp_v = q.pop_front();
                    chk("rnd_order", 128'(d_if.data), 128'(exp_v));
                end
            end
            if (in_fire) begin
                q.push_back(u_if.data);
                seq++;
            end
            step();
        end
        u_if.valid = 1'b0;
        d_if.ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 10) begin
            if (d_if.valid) begin
                exp_v = q.pop_front();
                chk("drain_order", 128'(d_if.data), 128'(exp_v));
            end
            step();
            guard++;
        end
        chk("drain_left",  128'(q.size()),  128'd0);
        chk("drain_occ",   128'(occupancy), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
